// File: rtl/reg_file_if.sv
// Decode read ports plus the writeback write port of the MIPS register file.
// The master side is decode/writeback; the slave side is the register file.
interface reg_file_if #(
  parameter int ADDR_SIZE = 5,
  parameter int WORD_SIZE = 32
);
  logic                 en;
  logic [ADDR_SIZE-1:0] rs_addr;
  logic [ADDR_SIZE-1:0] rt_addr;
  logic [WORD_SIZE-1:0] rs_data;
  logic [WORD_SIZE-1:0] rt_data;
  logic                 rd_en;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [WORD_SIZE-1:0] rd_data;

  modport master (
    output en, rs_addr, rt_addr, rd_en, rd_addr, rd_data,
    input  rs_data, rt_data
  );

  modport slave (
    input  en, rs_addr, rt_addr, rd_en, rd_addr, rd_data,
    output rs_data, rt_data
  );
endinterface

// File: rtl/reg_file.sv
// MIPS register file: two registered read ports, one writeback port, $0 hardwired to zero.
// Define REG_FILE_WRITE_BYPASS_EN to forward same-edge writeback data onto the read ports.
module reg_file #(
  parameter int ADDR_SIZE = 5,
  parameter int WORD_SIZE = 32
) (
  input  logic        clk,
  input  logic        rst,
  reg_file_if.slave   bus
);
  localparam int NREG = 2 ** ADDR_SIZE;

  logic [WORD_SIZE-1:0] regs_q [NREG];
  logic [WORD_SIZE-1:0] rs_data_q, rs_data_d;
  logic [WORD_SIZE-1:0] rt_data_q, rt_data_d;
  logic                 wr_hit;

  // Entry 0 is never written, so it keeps its reset value of zero.
  assign wr_hit = bus.rd_en && (bus.rd_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_hit) begin
      regs_q[bus.rd_addr] <= bus.rd_data;
    end
  end

  always_comb begin
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    if (bus.en) begin
      rs_data_d = (bus.rs_addr == '0) ? '0 : regs_q[bus.rs_addr];
      rt_data_d = (bus.rt_addr == '0) ? '0 : regs_q[bus.rt_addr];
`ifdef REG_FILE_WRITE_BYPASS_EN
      if (wr_hit && (bus.rd_addr == bus.rs_addr)) rs_data_d = bus.rd_data;
      if (wr_hit && (bus.rd_addr == bus.rt_addr)) rt_data_d = bus.rd_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data_q <= '0;
      rt_data_q <= '0;
    end else begin
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
    end
  end

  assign bus.rs_data = rs_data_q;
  assign bus.rt_data = rt_data_q;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: vector table, hand sequences, and random traffic vs a model.
module tb_reg_file;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_if #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) bus ();
  reg_file #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

`ifdef REG_FILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  int n_total = 0;
  int n_pass  = 0;
  logic [DW-1:0] model [2**AW];
  logic [DW-1:0] exp_rs = '0, exp_rt = '0;

  typedef struct {
    bit          en;
    logic [4:0]  rs, rt;
    bit          we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] x_rs, x_rt;
  } vec_t;
  vec_t vecs [$];

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a, input bit we,
                                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (a == 0) return '0;
    if (BYPASS && we && wa == a) return wd;
    return model[a];
  endfunction

  // Drives one cycle of inputs, advances the model, returns #1 after the edge.
  task automatic drive(input bit en, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bus.en = en; bus.rs_addr = rs; bus.rt_addr = rt;
    bus.rd_en = we; bus.rd_addr = wa; bus.rd_data = wd;
    if (en) begin
      exp_rs = ref_read(rs, we, wa, wd);
      exp_rt = ref_read(rt, we, wa, wd);
    end
    if (we && wa != 0) model[wa] = wd;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
    bus.en = 0; bus.rs_addr = 0; bus.rt_addr = 0;
    bus.rd_en = 0; bus.rd_addr = 0; bus.rd_data = 0;

    // Hand-computed vectors: write/read latency, $0 discard, stall hold, stalled write.
    vecs.push_back('{1, 0,  0,  1, 7,  32'h12345678, 32'h0,        32'h0});
    vecs.push_back('{1, 7,  7,  1, 0,  32'hFFFFFFFF, 32'h12345678, 32'h12345678});
    vecs.push_back('{1, 0,  0,  1, 10, 32'hA,        32'h0,        32'h0});
    vecs.push_back('{1, 10, 7,  1, 11, 32'hB,        32'hA,        32'h12345678});
    vecs.push_back('{0, 11, 11, 0, 0,  32'h0,        32'hA,        32'h12345678});
    vecs.push_back('{0, 11, 11, 1, 9,  32'h55,       32'hA,        32'h12345678});
    vecs.push_back('{0, 11, 9,  0, 0,  32'h0,        32'hA,        32'h12345678});
    vecs.push_back('{1, 11, 9,  0, 0,  32'h0,        32'hB,        32'h55});
    vecs.push_back('{1, 0,  0,  1, 3,  32'h1,        32'h0,        32'h0});

    #12;
    check("reset_rs", bus.rs_data, '0);
    check("reset_rt", bus.rt_data, '0);
    @(posedge clk); #1;
    rst = 0;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].rs, vecs[i].rt, vecs[i].we, vecs[i].wa, vecs[i].wd);
      check($sformatf("vec%0d_rs", i), bus.rs_data, vecs[i].x_rs);
      check($sformatf("vec%0d_rt", i), bus.rt_data, vecs[i].x_rt);
    end

    // Same-edge write and read of r3 (holds 1, gets 2).
    drive(1, 3, 3, 1, 3, 32'h2);
    check("bypass_rs", bus.rs_data, BYPASS ? 32'h2 : 32'h1);
    check("bypass_rt", bus.rt_data, BYPASS ? 32'h2 : 32'h1);
    drive(1, 3, 0, 0, 0, 32'h0);
    check("after_bypass_rs", bus.rs_data, 32'h2);
    check("after_bypass_rt", bus.rt_data, 32'h0);

    // Mid-cycle asynchronous reset after r5 = DEADBEEF is visible.
    drive(1, 0, 0, 1, 5, 32'hDEADBEEF);
    drive(1, 5, 5, 0, 0, 32'h0);
    check("r5_rs", bus.rs_data, 32'hDEADBEEF);
    check("r5_rt", bus.rt_data, 32'hDEADBEEF);
    #3 rst = 1;
    #1;
    check("async_rst_rs", bus.rs_data, '0);
    check("async_rst_rt", bus.rt_data, '0);
    bus.en = 1; bus.rs_addr = 5; bus.rt_addr = 6;
    bus.rd_en = 1; bus.rd_addr = 6; bus.rd_data = 32'h1;
    @(posedge clk); #1;
    check("rst_hold_rs", bus.rs_data, '0);
    check("rst_hold_rt", bus.rt_data, '0);
    rst = 0;
    for (int i = 0; i < 2**AW; i++) model[i] = '0;
    exp_rs = '0; exp_rt = '0;
    drive(1, 5, 6, 0, 0, 32'h0);
    check("post_rst_r5", bus.rs_data, '0);
    check("post_rst_r6", bus.rt_data, '0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, AW'($urandom), AW'($urandom),
            $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7) == 0 ? 0 : $urandom), $urandom);
      check($sformatf("rand%0d_rs", i), bus.rs_data, exp_rs);
      check($sformatf("rand%0d_rt", i), bus.rt_data, exp_rt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
